// File: rtl/ibex_register_file_mp.sv
// Flop-based multi-port register file with a per-register busy scoreboard.
// Optional write-enable/conflict checker enabled by defining IBEX_RF_WREN_CHECK_EN.
module ibex_register_file_mp #(
    parameter int unsigned          NumRegs      = 32,
    parameter int unsigned          DataWidth    = 32,
    parameter int unsigned          NumRead      = 2,
    parameter int unsigned          NumWrite     = 2,
    parameter bit                   WriteThrough = 1'b1,
    parameter logic [DataWidth-1:0] WordZeroVal  = '0,
    localparam int unsigned         AW           = $clog2(NumRegs)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumRead*AW-1:0]         raddr_i,
    output logic [NumRead*DataWidth-1:0]  rdata_o,
    output logic [NumRead-1:0]            rbusy_o,
    input  logic [NumWrite*AW-1:0]        waddr_i,
    input  logic [NumWrite*DataWidth-1:0] wdata_i,
    input  logic [NumWrite-1:0]           we_i,
    input  logic                          issue_valid_i,
    input  logic [AW-1:0]                 issue_addr_i,
    output logic                          err_o
);

    // Register 0 is never stored: it is hardwired to WordZeroVal and never busy.
    logic [DataWidth-1:0] rf_q [NumRegs-1:1];
    logic [DataWidth-1:0] rf_d [NumRegs-1:1];
    logic [NumRegs-1:1]   busy_q;
    logic [NumRegs-1:1]   busy_d;
    logic [NumRegs-1:1]   wdec_s [NumWrite];

    // Per-port write decoders; out-of-range and register-0 targets decode to nothing.
    always_comb begin
        for (int w = 0; w < NumWrite; w++) begin
            wdec_s[w] = '0;
            for (int i = 1; i < NumRegs; i++) begin
                wdec_s[w][i] = we_i[w] && (waddr_i[w*AW +: AW] == AW'(i));
            end
        end
    end

    // Next state: higher port indices overwrite lower ones; an issue beats a same-cycle clear.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        for (int i = 1; i < NumRegs; i++) begin
            for (int w = 0; w < NumWrite; w++) begin
                rf_d[i]   = wdec_s[w][i] ? wdata_i[w*DataWidth +: DataWidth] : rf_d[i];
                busy_d[i] = wdec_s[w][i] ? 1'b0 : busy_d[i];
            end
            busy_d[i] = (issue_valid_i && (issue_addr_i == AW'(i))) ? 1'b1 : busy_d[i];
        end
    end

    // Combinational read ports with optional bypass of the winning same-cycle write.
    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int r = 0; r < NumRead; r++) begin
            rdata_o[r*DataWidth +: DataWidth] = WordZeroVal;
            for (int i = 1; i < NumRegs; i++) begin
                if (raddr_i[r*AW +: AW] == AW'(i)) begin
                    rdata_o[r*DataWidth +: DataWidth] = rf_q[i];
                    rbusy_o[r] = busy_q[i];
                    for (int w = 0; w < NumWrite; w++) begin
                        rdata_o[r*DataWidth +: DataWidth] = (WriteThrough && wdec_s[w][i]) ?
                            wdata_i[w*DataWidth +: DataWidth] : rdata_o[r*DataWidth +: DataWidth];
                    end
                end else begin
                    rbusy_o[r] = rbusy_o[r];
                end
            end
        end
    end

    // Register array and busy scoreboard; reset overrides any same-cycle write or issue.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 1; i < NumRegs; i++) begin
                rf_q[i] <= WordZeroVal;
            end
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

`ifdef IBEX_RF_WREN_CHECK_EN
    logic err_q;
    logic err_event_s;

    function automatic logic is_onehot0(input logic [NumRegs-1:1] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 1; i < NumRegs; i++) begin
            cnt = cnt + {31'd0, vec[i]};
        end
        return (cnt <= 32'd1);
    endfunction

    // Flag malformed decoders and any two enabled ports aimed at the same nonzero address.
    always_comb begin
        err_event_s = 1'b0;
        for (int w = 0; w < NumWrite; w++) begin
            err_event_s = err_event_s | ~is_onehot0(wdec_s[w]);
            for (int v = w + 1; v < NumWrite; v++) begin
                err_event_s = err_event_s |
                    (we_i[w] && we_i[v] &&
                     (waddr_i[w*AW +: AW] == waddr_i[v*AW +: AW]) &&
                     (waddr_i[w*AW +: AW] != '0));
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_event_s;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
